// File: rtl/dot_row_tracker.sv
// dot_row_tracker: occupancy tracker for one maze row of dot/pellet sites.
//
// Ports:
//   i_clk            system clock
//   i_reset          asynchronous active-high reset; loads i_dotRowStart
//   i_restore        synchronous reload of the start pattern (new level)
//   i_freeze         suppresses eating while asserted
//   i_atIntersection Pac-Man is centred on a tile this cycle
//   i_pacX, i_pacY   Pac-Man pixel coordinates
//   i_dotY           tile row served by this instance
//   i_dotRowStart    start pattern, bit NUM_COLS-1 is the leftmost site
//   i_pelletMask     1 marks a power pellet site, same bit order
//   o_stillHere      registered occupancy
//   o_anyLeft        OR of the occupancy
//   o_remaining      registered popcount of the occupancy
//   o_dotEaten       one-cycle pulse when a regular dot is cleared
//   o_pelletEaten    one-cycle pulse when a power pellet is cleared
//   o_eatCol         tile column of the last cleared site
//   o_rowClear       one-cycle pulse when eating clears the last site
module dot_row_tracker #(
    parameter int NUM_COLS   = 12,
    parameter int COL_BASE   = 1,
    parameter int COORD_W    = 10,
    parameter int TILE_SHIFT = 4,
    parameter int ROW_W      = 5,
    localparam int RW        = $clog2(NUM_COLS + 1)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_restore,
    input  logic                i_freeze,
    input  logic                i_atIntersection,
    input  logic [COORD_W-1:0]  i_pacX,
    input  logic [COORD_W-1:0]  i_pacY,
    input  logic [ROW_W-1:0]    i_dotY,
    input  logic [NUM_COLS-1:0] i_dotRowStart,
    input  logic [NUM_COLS-1:0] i_pelletMask,
    output logic [NUM_COLS-1:0] o_stillHere,
    output logic                o_anyLeft,
    output logic [RW-1:0]       o_remaining,
    output logic                o_dotEaten,
    output logic                o_pelletEaten,
    output logic [ROW_W-1:0]    o_eatCol,
    output logic                o_rowClear
);

    function automatic logic [RW-1:0] popcount(input logic [NUM_COLS-1:0] v);
        logic [RW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_COLS; i++) c = c + RW'(v[i]);
        return c;
    endfunction

    logic [NUM_COLS-1:0] r_still;
    logic [RW-1:0]       r_rem;
    logic                r_dot;
    logic                r_pel;
    logic                r_clr;
    logic [ROW_W-1:0]    r_eat_col;

    logic [COORD_W-1:0]  w_tx;
    logic [COORD_W-1:0]  w_ty;
    logic [NUM_COLS-1:0] w_col_sel;
    logic [NUM_COLS-1:0] w_hit_vec;
    logic                w_qual;
    logic                w_hit;
    logic                w_pel;

    assign w_tx = i_pacX >> TILE_SHIFT;
    assign w_ty = i_pacY >> TILE_SHIFT;

    // One-hot column decode; a tile outside the row selects nothing, so no wrap.
    genvar g;
    generate
        for (g = 0; g < NUM_COLS; g++) begin : g_col
            assign w_col_sel[g] = (w_tx == COORD_W'(COL_BASE + NUM_COLS - 1 - g));
        end
    endgenerate

    assign w_qual    = i_atIntersection & ~i_freeze & ~i_restore & (w_ty == COORD_W'(i_dotY));
    assign w_hit_vec = w_col_sel & r_still & {NUM_COLS{w_qual}};
    assign w_hit     = |w_hit_vec;
    assign w_pel     = |(w_hit_vec & i_pelletMask);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_still   <= i_dotRowStart;
            r_rem     <= popcount(i_dotRowStart);
            r_dot     <= 1'b0;
            r_pel     <= 1'b0;
            r_clr     <= 1'b0;
            r_eat_col <= '0;
        end else if (i_restore) begin
            r_still <= i_dotRowStart;
            r_rem   <= popcount(i_dotRowStart);
            r_dot   <= 1'b0;
            r_pel   <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            r_dot <= w_hit & ~w_pel;
            r_pel <= w_hit & w_pel;
            // The site being cleared is the last one when the count is 1.
            r_clr <= w_hit & (r_rem == RW'(1));
            if (w_hit) begin
                r_still   <= r_still & ~w_hit_vec;
                r_rem     <= r_rem - RW'(1);
                r_eat_col <= ROW_W'(w_tx);
            end
        end
    end

    assign o_stillHere   = r_still;
    assign o_anyLeft     = |r_still;
    assign o_remaining   = r_rem;
    assign o_dotEaten    = r_dot;
    assign o_pelletEaten = r_pel;
    assign o_rowClear    = r_clr;
    assign o_eatCol      = r_eat_col;

endmodule

// File: tb/tb_dot_row_tracker.sv
// tb_dot_row_tracker: directed self-checking bench for dot_row_tracker.
module tb_dot_row_tracker;

    logic        clk = 1'b0;
    logic        reset, restore, freeze, at;
    logic [9:0]  pac_x, pac_y;
    logic [4:0]  dot_y;
    logic [11:0] start, pmask;
    logic [11:0] still;
    logic        any_left, dot_e, pel_e, row_clr;
    logic [3:0]  rem;
    logic [4:0]  eat_col;
    int          vecs = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    dot_row_tracker dut (
        .i_clk(clk), .i_reset(reset), .i_restore(restore), .i_freeze(freeze),
        .i_atIntersection(at), .i_pacX(pac_x), .i_pacY(pac_y), .i_dotY(dot_y),
        .i_dotRowStart(start), .i_pelletMask(pmask),
        .o_stillHere(still), .o_anyLeft(any_left), .o_remaining(rem),
        .o_dotEaten(dot_e), .o_pelletEaten(pel_e), .o_eatCol(eat_col),
        .o_rowClear(row_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic aim(input int col, input int row);
        pac_x = 10'(col * 16 + 8);
        pac_y = 10'(row * 16 + 8);
    endtask

    task automatic expect_state(input string nm, input logic [11:0] s, input logic [3:0] r,
                                input logic d, input logic p, input logic c, input logic [4:0] ec);
        vecs++;
        if (still !== s || rem !== r || any_left !== (s != 0) || dot_e !== d ||
            pel_e !== p || row_clr !== c || eat_col !== ec) begin
            errs++;
            $display("FAIL %s: got still=%h rem=%0d any=%b dot=%b pel=%b clr=%b col=%0d expected still=%h rem=%0d any=%b dot=%b pel=%b clr=%b col=%0d",
                     nm, still, rem, any_left, dot_e, pel_e, row_clr, eat_col,
                     s, r, s != 0, d, p, c, ec);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; restore = 1'b0; freeze = 1'b0; at = 1'b0;
        start = 12'hFFF; pmask = 12'h801; dot_y = 5'd5; aim(0, 0);
        step();
        step();
        reset = 1'b0;
        step();
        expect_state("reset", 12'hFFF, 4'd12, 0, 0, 0, 5'd0);
    endtask

    task automatic test_dot_eat();
        aim(3, 5);
        at = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            expect_state($sformatf("dot_hold%0d", k), 12'hDFF, 4'd11, k == 0, 0, 0, 5'd3);
        end
        at = 1'b0;
        step();
        expect_state("dot_after", 12'hDFF, 4'd11, 0, 0, 0, 5'd3);
    endtask

    task automatic test_pellet();
        aim(1, 5);
        at = 1'b1;
        step();
        at = 1'b0;
        expect_state("pellet", 12'h5FF, 4'd10, 0, 1, 0, 5'd1);
        step();
        expect_state("pellet_after", 12'h5FF, 4'd10, 0, 0, 0, 5'd1);
    endtask

    task automatic test_misses();
        int cols[4] = '{2, 0, 13, 2};
        int rows[4] = '{6, 5, 5, 5};
        for (int k = 0; k < 4; k++) begin
            aim(cols[k], rows[k]);
            freeze = (k == 3);
            at = 1'b1;
            step();
            at = 1'b0;
            freeze = 1'b0;
            step();
            expect_state($sformatf("miss%0d", k), 12'h5FF, 4'd10, 0, 0, 0, 5'd1);
        end
    endtask

    task automatic test_row_clear();
        start = 12'h001;
        restore = 1'b1;
        step();
        restore = 1'b0;
        expect_state("restore_001", 12'h001, 4'd1, 0, 0, 0, 5'd1);
        aim(12, 5);
        at = 1'b1;
        step();
        expect_state("row_clear", 12'h000, 4'd0, 0, 1, 1, 5'd12);
        step();
        at = 1'b0;
        expect_state("empty_site", 12'h000, 4'd0, 0, 0, 0, 5'd12);
    endtask

    task automatic test_restore_vs_hit();
        start = 12'hFFF;
        restore = 1'b1;
        step();
        restore = 1'b0;
        start = 12'h123;
        step();
        expect_state("restore_fff", 12'hFFF, 4'd12, 0, 0, 0, 5'd12);
        start = 12'hFFF;
        aim(3, 5);
        at = 1'b1;
        restore = 1'b1;
        step();
        at = 1'b0;
        restore = 1'b0;
        expect_state("restore_hit", 12'hFFF, 4'd12, 0, 0, 0, 5'd12);
        step();
        expect_state("restore_hit_after", 12'hFFF, 4'd12, 0, 0, 0, 5'd12);
    endtask

    task automatic test_async_reset();
        aim(4, 5);
        at = 1'b1;
        step();
        at = 1'b0;
        expect_state("pre_reset", 12'hEFF, 4'd11, 1, 0, 0, 5'd4);
        start = 12'h0F0;
        #2 reset = 1'b1;
        #1;
        expect_state("async_reset", 12'h0F0, 4'd4, 0, 0, 0, 5'd0);
        step();
        reset = 1'b0;
        step();
        expect_state("post_reset", 12'h0F0, 4'd4, 0, 0, 0, 5'd0);
    endtask

    initial begin
        test_reset();
        test_dot_eat();
        test_pellet();
        test_misses();
        test_row_clear();
        test_restore_vs_hit();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/dot_row_tracker.md
Name: dot_row_tracker

Overview:
- Parametrised successor to the fixed 12-dot row tracker; replaces the per-dot instance array with a single registered occupancy vector.
- Tracks one maze row of NUM_COLS dot/pellet sites and clears a site when Pac-Man's tile coincides at an intersection.
- Emits registered eat events (regular and power pellet), a live remaining count and a row-clear pulse for the score, ghost-mode and level logic.
- Instanced once per maze row by the board controller.

Parameters:
- NUM_COLS, 12, number of sites in the row (1..32).
- COL_BASE, 1, tile column of the leftmost site.
- COORD_W, 10, width of pixel coordinates pacX/pacY.
- TILE_SHIFT, 4, log2 of tile size in pixels; tile = coord >> TILE_SHIFT.
- ROW_W, 5, width of dotY tile row index.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- restore  in  1  synchronous reload of start pattern (new level)
- freeze  in  1  suppress eating (death/intermission)
- atIntersection  in  1  Pac-Man centred on a tile this cycle
- pacX  in  COORD_W  Pac-Man pixel X
- pacY  in  COORD_W  Pac-Man pixel Y
- dotY  in  ROW_W  tile row of this instance
- dotRowStart  in  NUM_COLS  start pattern; bit NUM_COLS-1 = leftmost site
- pelletMask  in  NUM_COLS  1 = site is a power pellet (same bit order)
- stillHere  out  NUM_COLS  current occupancy, registered
- anyLeft  out  1  |stillHere (combinational from register)
- remaining  out  $clog2(NUM_COLS+1)  popcount of stillHere, registered
- dotEaten  out  1  one-cycle pulse: regular dot cleared
- pelletEaten  out  1  one-cycle pulse: power pellet cleared
- eatCol  out  ROW_W  tile column of last cleared site, held until next eat
- rowClear  out  1  one-cycle pulse: last site in row cleared by eating

Behaviour:
- Async reset: stillHere <= dotRowStart, remaining <= popcount(dotRowStart), dotEaten/pelletEaten/rowClear <= 0, eatCol <= 0.
- Tile decode: tx = pacX >> TILE_SHIFT, ty = pacY >> TILE_SHIFT (compared zero-extended to ROW_W). Site bit i sits at column COL_BASE + (NUM_COLS-1-i).
- Hit: atIntersection & !freeze & !restore & ty == dotY & COL_BASE <= tx <= COL_BASE+NUM_COLS-1 & stillHere[bit] = 1. Columns outside the range never hit; no wrap.
- On hit, at the next clock edge:
  - stillHere[bit] <= 0; remaining <= remaining - 1.
  - eatCol <= tx.
  - dotEaten <= !pelletMask[bit]; pelletEaten <= pelletMask[bit].
  - rowClear <= (remaining == 1).
  - Exactly one of dotEaten/pelletEaten pulses. Latency: 1 cycle from the qualifying input cycle.
- No hit: all three pulses deasserted the next cycle.
- atIntersection held several cycles on the same tile: only the first cycle hits (bit already 0); one pulse total.
- Already-empty site: no pulse, no count change.
- restore: stillHere <= dotRowStart, remaining <= popcount(dotRowStart), pulses <= 0, eatCol held. Restore overrides a simultaneous hit; that hit is discarded.
- freeze masks hits only; restore still acts while frozen.
- dotRowStart and pelletMask are sampled only at reset/restore (dotRowStart) or at a hit (pelletMask); changes at other times have no effect on occupancy.
- remaining never underflows; it always equals popcount(stillHere).
- Reset mid-operation: immediate return to reset values regardless of pending hit.

Test Plan:
- Reset with dotRowStart=12'hFFF, pelletMask=12'h801 -> stillHere=12'hFFF, remaining=12, anyLeft=1, all pulses 0.
- dotY=5, pacX=16*3+8, pacY=16*5+8, atIntersection=1 for 4 cycles -> stillHere=12'hDFF (bit 9 cleared), dotEaten high exactly one cycle after the first cycle, eatCol=3, remaining=11.
- pacX on column 1 (bit 11, pellet) -> pelletEaten pulses once, dotEaten stays 0, stillHere bit 11=0.
- Hits with pacY at tile row 6, at tile column 0, or at column 13, and a hit with freeze=1 -> no state change and no pulses.
- Start 12'h001, eat column 12 -> rowClear and pelletEaten pulse the same cycle, remaining=0, anyLeft=0.
- restore asserted in the same cycle as a valid hit -> stillHere=dotRowStart, no pulse. Async reset asserted mid-pulse -> pulse drops immediately, occupancy reloads.
